// File: rtl/samsung_ir_rx.sv
// rtl/samsung_ir_rx.sv - Samsung-protocol IR frame decoder with ready/ack command handoff
//
// Decodes frames from a demodulated, active-low IR receiver pin into a 32-bit
// command word. All pulse widths are measured on an internal tick of
// TICK_DIV clk25 cycles (20 us at 25 MHz with the default).
//
// Ports:
//   clk25     in   1   system clock
//   rst       in   1   asynchronous active-high reset
//   enable    in   1   1 = receive frames, 0 = hold FSM in IDLE
//   ir_input  in   1   raw IR receiver output (asynchronous, low = mark)
//   ack       in   1   consumer acknowledge of the current command
//   ready     out  1   command holds a valid, unacknowledged frame
//   command   out  32  decoded frame, first received bit in bit 0
//   busy      out  1   frame in progress (FSM not in IDLE)
//
// Optional feature macro: IR_CHECK_EN
//   defined   - a frame is delivered only if command[31:24] == ~command[23:16]
//   undefined - every well-timed 32-bit frame is delivered
`timescale 1ns/1ps

module samsung_ir_rx #(
  parameter int TICK_DIV = 500,
  parameter int LEAD_MIN = 180,
  parameter int LEAD_MAX = 270,
  parameter int BIT_MIN  = 14,
  parameter int BIT_MAX  = 42,
  parameter int ONE_MIN  = 63,
  parameter int ONE_MAX  = 105,
  parameter int TIMEOUT  = 300
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        enable,
  input  logic        ir_input,
  input  logic        ack,
  output logic        ready,
  output logic [31:0] command,
  output logic        busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic [8:0] LEAD_MIN_W = 9'(LEAD_MIN);
  localparam logic [8:0] LEAD_MAX_W = 9'(LEAD_MAX);
  localparam logic [8:0] BIT_MIN_W  = 9'(BIT_MIN);
  localparam logic [8:0] BIT_MAX_W  = 9'(BIT_MAX);
  localparam logic [8:0] ONE_MIN_W  = 9'(ONE_MIN);
  localparam logic [8:0] ONE_MAX_W  = 9'(ONE_MAX);
  localparam logic [8:0] TIMEOUT_W  = 9'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    DONE
  } state_t;

  state_t        state;
  logic          sync1, sync2;
  logic          sample;
  logic [TW-1:0] tick_cnt;
  logic [8:0]    width;
  logic [4:0]    bit_cnt;
  logic [31:0]   shreg;

  logic tick, fall, rise, timeout;

  function automatic logic in_range(input logic [8:0] w, input logic [8:0] lo,
                                    input logic [8:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  assign tick    = (tick_cnt == TICK_LAST);
  // Edges are judged between consecutive tick samples, so glitches shorter
  // than a tick are mostly filtered out.
  assign fall    = tick && sample && !sync2;
  assign rise    = tick && !sample && sync2;
  assign timeout = (width >= TIMEOUT_W);
  assign busy    = (state != IDLE);

  // Synchronizer, tick prescaler, tick sampler and width counter.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      sample   <= 1'b1;
      tick_cnt <= '0;
      width    <= '0;
    end else begin
      sync1 <= ir_input;
      sync2 <= sync1;
      if (tick) begin
        tick_cnt <= '0;
        sample   <= sync2;
        // width holds the tick count since the previous edge at the moment
        // the FSM sees the next edge; it restarts at 1 on that edge.
        if (fall || rise)
          width <= 9'd1;
        else if (width != 9'd511)
          width <= width + 9'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ready   <= 1'b0;
      command <= '0;
    end else begin
      // Ack clears ready; a DONE in the same cycle overrides this below.
      if (ready && ack)
        ready <= 1'b0;

      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fall)
              state <= LEAD_MARK;
          end

          LEAD_MARK: begin
            if (rise)
              state <= in_range(width, LEAD_MIN_W, LEAD_MAX_W) ? LEAD_SPACE : IDLE;
            else if (timeout)
              state <= IDLE;
          end

          LEAD_SPACE: begin
            if (fall) begin
              bit_cnt <= '0;
              state   <= in_range(width, LEAD_MIN_W, LEAD_MAX_W) ? BIT_MARK : IDLE;
            end else if (timeout) begin
              state <= IDLE;
            end
          end

          BIT_MARK: begin
            if (rise)
              state <= in_range(width, BIT_MIN_W, BIT_MAX_W) ? BIT_SPACE : IDLE;
            else if (timeout)
              state <= IDLE;
          end

          BIT_SPACE: begin
            if (fall) begin
              if (in_range(width, BIT_MIN_W, BIT_MAX_W) ||
                  in_range(width, ONE_MIN_W, ONE_MAX_W)) begin
                // Right shift so the first bit on air ends up in bit 0.
                shreg <= {in_range(width, ONE_MIN_W, ONE_MAX_W), shreg[31:1]};
                if (bit_cnt == 5'd31) begin
                  state <= STOP_MARK;
                end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                  state   <= BIT_MARK;
                end
              end else begin
                state <= IDLE;
              end
            end else if (timeout) begin
              state <= IDLE;
            end
          end

          STOP_MARK: begin
            if (rise)
              state <= in_range(width, BIT_MIN_W, BIT_MAX_W) ? DONE : IDLE;
            else if (timeout)
              state <= IDLE;
          end

          DONE: begin
`ifdef IR_CHECK_EN
            if (shreg[31:24] == ~shreg[23:16]) begin
              command <= shreg;
              ready   <= 1'b1;
            end
`else
            command <= shreg;
            ready   <= 1'b1;
`endif
            state <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
